config_loader: RTL

Configuration sequencer for the island-style fabric's serial configuration chain. Accepts the bitstream as parallel words over a valid/ready stream and shifts it bit-serially into the fabric's `config_in`/`config_clk`/`config_en` chain, bit 0 first. It generates the chain clock from the system clock and reports progress with `busy`/`done`. It sits between the host/bitstream memory and the fabric top module, replacing bench-driven configuration tasks.

---
 rtl/config_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// config_loader: shifts parallel bitstream words bit-serially (bit 0 first) into the fabric config chain.
// Optional CRC-16-CCITT trailer check is enabled by defining CONFIG_LOADER_CRC_EN.
module config_loader #(
    parameter int CONFIG_WIDTH = 4651,
    parameter int WORD_WIDTH = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_in,
    output logic                  config_clk,
    output logic                  config_en,
    input  logic                  config_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int BW = $clog2(CONFIG_WIDTH + 1);
    localparam int WW = $clog2(WORD_WIDTH + 1);
    localparam int DW = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, CHECK, FINISH} state_t;

`ifdef CONFIG_LOADER_CRC_EN
    localparam state_t AFTER_DATA = CHECK;
`else
    localparam state_t AFTER_DATA = FINISH;
`endif

    state_t state, next;
    logic [BW-1:0] bit_cnt;
    logic [WW-1:0] word_idx;
    logic [DW-1:0] div_cnt;
    logic [WORD_WIDTH-1:0] sreg;
    logic accept, div_end, last_bit, last_in_word, run_on;

    assign accept = word_valid && word_ready;
    assign div_end = div_cnt == DW'(CLK_DIV - 1);
    assign last_bit = bit_cnt == BW'(CONFIG_WIDTH - 1);
    assign last_in_word = word_idx == WW'(WORD_WIDTH - 1);
    assign run_on = next inside {FETCH, LOW, HIGH, CHECK};
    assign config_in = sreg[0];

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? FETCH : IDLE;
            FETCH:   next = accept ? LOW : FETCH;
            LOW:     next = div_end ? HIGH : LOW;
            HIGH:    next = !div_end ? HIGH : last_bit ? AFTER_DATA : last_in_word ? FETCH : LOW;
            CHECK:   next = accept ? FINISH : CHECK;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bit_cnt <= '0;
            word_idx <= '0;
            div_cnt <= '0;
            sreg <= '0;
            word_ready <= 1'b0;
            config_clk <= 1'b0;
            config_en <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= next;
            div_cnt <= (next == state && (state == LOW || state == HIGH)) ? div_cnt + 1'b1 : '0;
            if (state == IDLE && start)
                bit_cnt <= '0;
            if (state == FETCH && accept) begin
                sreg <= word_data;
                word_idx <= '0;
            end
            if (state == HIGH && div_end) begin
                bit_cnt <= bit_cnt + 1'b1;
                word_idx <= word_idx + 1'b1;
            end
            // Shift only when the next bit is presented, so config_in never moves outside LOW
            if (state == HIGH && next == LOW)
                sreg <= sreg >> 1;
            word_ready <= next == FETCH || next == CHECK;
            config_clk <= next == HIGH;
            config_en <= run_on;
            busy <= run_on;
            done <= (state == IDLE && start) ? 1'b0 : (next == FINISH) ? 1'b1 : done;
        end
    end

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] crc;
    logic tail_unused;

    // CRC and chain-tail capture happen on the edge that raises config_clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 16'hFFFF;
            error <= 1'b0;
            tail_unused <= 1'b0;
        end else if (state == IDLE && start) begin
            crc <= 16'hFFFF;
            error <= 1'b0;
        end else if (state == LOW && div_end) begin
            crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ config_in) ? 16'h1021 : 16'h0000);
            tail_unused <= config_out;
        end else if (state == CHECK && accept) begin
            error <= 16'(word_data) != crc;
        end
    end
`else
    logic unused_tail;
    assign unused_tail = config_out;
    assign error = 1'b0;
`endif
endmodule
